// File: rtl/ft64_fcu_pkg.sv
// Shared types for the FT64 flow-control resolution stage: result kinds,
// resolver FSM states and the layout of one queued result.
package ft64_fcu_pkg;

    localparam int FCU_WID  = 64;
    localparam int FCU_AMSB = 31;
    localparam int FCU_TAGW = 4;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'd0,
        KIND_JUMP   = 2'd1,
        KIND_RETURN = 2'd2,
        KIND_WAIT   = 2'd3
    } fcu_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_WAIT  = 2'd2
    } fcu_state_e;

    typedef struct packed {
        logic [FCU_TAGW-1:0] id;
        fcu_kind_e           kind;
        logic [FCU_WID-1:0]  bus;
        logic                taken;
        logic [FCU_AMSB:0]   tgt;
        logic [FCU_AMSB:0]   nextpc;
        logic                ptaken;
        logic [FCU_AMSB:0]   ptgt;
    } fcu_entry_t;

endpackage

// File: rtl/ft64_fcu_resolve_if.sv
// Bundle of the result input, ROB writeback, fetch redirect and wait-counter
// signals of the resolution stage. The slave side is the resolver itself.
interface ft64_fcu_resolve_if #(
    parameter int WID  = 64,
    parameter int AMSB = 31,
    parameter int TAGW = 4
);
    logic            fcu_v_i;
    logic            fcu_rdy_o;
    logic [TAGW-1:0] fcu_id_i;
    logic [1:0]      fcu_kind_i;
    logic [WID-1:0]  fcu_bus_i;
    logic            fcu_taken_i;
    logic [AMSB:0]   fcu_tgt_i;
    logic [AMSB:0]   fcu_nextpc_i;
    logic            fcu_ptaken_i;
    logic [AMSB:0]   fcu_ptgt_i;
    logic [WID-1:0]  waitctr_i;
    logic            flush_i;
    logic            cmt_v_o;
    logic [TAGW-1:0] cmt_id_o;
    logic [WID-1:0]  cmt_bus_o;
    logic            cmt_mispred_o;
    logic            rdr_v_o;
    logic [AMSB:0]   rdr_pc_o;
    logic            rdr_ack_i;
    logic            wait_active_o;

    modport slave (
        input  fcu_v_i, fcu_id_i, fcu_kind_i, fcu_bus_i, fcu_taken_i, fcu_tgt_i,
               fcu_nextpc_i, fcu_ptaken_i, fcu_ptgt_i, waitctr_i, flush_i, rdr_ack_i,
        output fcu_rdy_o, cmt_v_o, cmt_id_o, cmt_bus_o, cmt_mispred_o,
               rdr_v_o, rdr_pc_o, wait_active_o
    );

    modport master (
        output fcu_v_i, fcu_id_i, fcu_kind_i, fcu_bus_i, fcu_taken_i, fcu_tgt_i,
               fcu_nextpc_i, fcu_ptaken_i, fcu_ptgt_i, waitctr_i, flush_i, rdr_ack_i,
        input  fcu_rdy_o, cmt_v_o, cmt_id_o, cmt_bus_o, cmt_mispred_o,
               rdr_v_o, rdr_pc_o, wait_active_o
    );
endinterface

// File: rtl/ft64_fcu_fifo.sv
// Small synchronous result queue. Clear wins over push/pop; pointers wrap
// naturally because DEPTH is a power of two (DEPTH >= 2).
module ft64_fcu_fifo
    import ft64_fcu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  fcu_entry_t    din_i,
    input  logic          pop_i,
    input  logic          clr_i,
    output fcu_entry_t    dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    fcu_entry_t    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem[rptr];

    // Storage write; entries carry no reset since count gates their validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= din_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else if (clr_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count_o <= count_o + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ft64_fcu_resolve.sv
// Flow-control resolution: queues resolved results, writes them back to the
// ROB one per cycle, raises a held fetch redirect on a mispredict and stalls
// WAIT instructions until the wait counter reaches one.
module ft64_fcu_resolve
    import ft64_fcu_pkg::*;
#(
    parameter int WID   = FCU_WID,
    parameter int AMSB  = FCU_AMSB,
    parameter int DEPTH = 4,
    parameter int TAGW  = FCU_TAGW
) (
    input logic              clk_i,
    input logic              rst_ni,
    ft64_fcu_resolve_if.slave io
);
    localparam int CW = $clog2(DEPTH) + 1;

    fcu_entry_t      in_ent;
    fcu_entry_t      head;
    logic            push, pop, clr, full, empty;
    logic [CW-1:0]   count;
    fcu_state_e      state, state_nxt;
    logic            cmt_ld, cmt_mis_nxt, rdr_ld;
    logic [WID-1:0]  cmt_bus_nxt;
    logic            cmt_v, cmt_mis;
    logic [TAGW-1:0] cmt_id;
    logic [WID-1:0]  cmt_bus;
    logic [AMSB:0]   rdr_pc;

    // JUMP/RETURN are unconditional, so only their target can be wrong.
    function automatic logic mispredict(input fcu_entry_t e);
        case (e.kind)
            KIND_BRANCH:             return (e.taken != e.ptaken) || (e.taken && (e.tgt != e.ptgt));
            KIND_JUMP, KIND_RETURN:  return e.tgt != e.ptgt;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [FCU_AMSB:0] redirect_pc(input fcu_entry_t e);
        return ((e.kind != KIND_BRANCH) || e.taken) ? e.tgt : e.nextpc;
    endfunction

    // Pack the incoming result into a queue entry.
    always_comb begin
        in_ent        = '0;
        in_ent.id     = io.fcu_id_i;
        in_ent.kind   = fcu_kind_e'(io.fcu_kind_i);
        in_ent.bus    = io.fcu_bus_i;
        in_ent.taken  = io.fcu_taken_i;
        in_ent.tgt    = io.fcu_tgt_i;
        in_ent.nextpc = io.fcu_nextpc_i;
        in_ent.ptaken = io.fcu_ptaken_i;
        in_ent.ptgt   = io.fcu_ptgt_i;
    end

    assign io.fcu_rdy_o = !full && (state != ST_REDIR);
    assign push         = io.fcu_v_i && io.fcu_rdy_o && !io.flush_i;

    ft64_fcu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   (in_ent),
        .pop_i   (pop),
        .clr_i   (clr),
        .dout_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CW'(DEPTH));

    // Resolver state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state plus pop/clear/writeback decisions; flush overrides everything.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        clr         = 1'b0;
        cmt_ld      = 1'b0;
        cmt_mis_nxt = 1'b0;
        rdr_ld      = 1'b0;
        cmt_bus_nxt = head.bus;
        if (io.flush_i) begin
            clr       = 1'b1;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        if ((head.kind == KIND_WAIT) && (io.waitctr_i != WID'(1))) begin
                            state_nxt = ST_WAIT;
                        end else begin
                            pop    = 1'b1;
                            cmt_ld = 1'b1;
                            if (mispredict(head)) begin
                                cmt_mis_nxt = 1'b1;
                                rdr_ld      = 1'b1;
                                clr         = 1'b1;
                                state_nxt   = ST_REDIR;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (io.waitctr_i == WID'(1)) begin
                        pop         = 1'b1;
                        cmt_ld      = 1'b1;
                        cmt_bus_nxt = WID'(1);
                        state_nxt   = ST_IDLE;
                    end
                end
                ST_REDIR: begin
                    if (io.rdr_ack_i) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Registered writeback and redirect outputs; cmt_v/cmt_mispred are pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmt_v   <= 1'b0;
            cmt_mis <= 1'b0;
            cmt_id  <= '0;
            cmt_bus <= '0;
            rdr_pc  <= '0;
        end else begin
            cmt_v   <= cmt_ld;
            cmt_mis <= cmt_mis_nxt;
            if (cmt_ld) begin
                cmt_id  <= head.id;
                cmt_bus <= cmt_bus_nxt;
            end
            if (rdr_ld) rdr_pc <= redirect_pc(head);
        end
    end

    assign io.cmt_v_o       = cmt_v;
    assign io.cmt_mispred_o = cmt_mis;
    assign io.cmt_id_o      = cmt_id;
    assign io.cmt_bus_o     = cmt_bus;
    assign io.rdr_v_o       = (state == ST_REDIR);
    assign io.rdr_pc_o      = rdr_pc;
    assign io.wait_active_o = (state == ST_WAIT);
endmodule

// File: tb/tb_ft64_fcu_resolve.sv
// Bench for ft64_fcu_resolve: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_ft64_fcu_resolve;
    localparam int DEPTH    = 4;
    localparam int K_BRANCH = 0;
    localparam int K_JUMP   = 1;
    localparam int K_RETURN = 2;
    localparam int K_WAIT   = 3;

    typedef struct {
        logic [3:0]  id;
        int          kind;
        logic [63:0] bus;
        bit          taken;
        logic [31:0] tgt;
        logic [31:0] nextpc;
        bit          ptaken;
        logic [31:0] ptgt;
    } ent_t;

    logic clk;
    logic rst_n;
    int   ncmp  = 0;
    int   nfail = 0;

    ft64_fcu_resolve_if #(.WID(64), .AMSB(31), .TAGW(4)) io ();

    ft64_fcu_resolve #(.WID(64), .AMSB(31), .DEPTH(DEPTH), .TAGW(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    ent_t        mq[$];
    bit          m_redir, m_wait, m_cmt_v, m_mis;
    logic [3:0]  m_id;
    logic [63:0] m_bus;
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_redir = 0; m_wait = 0; m_cmt_v = 0; m_mis = 0;
        m_id = '0; m_bus = '0; m_pc = '0;
    endtask

    function automatic bit is_mis(input ent_t e);
        if (e.kind == K_BRANCH) return (e.taken != e.ptaken) || (e.taken && e.tgt != e.ptgt);
        if (e.kind == K_WAIT)   return 0;
        return e.tgt != e.ptgt;
    endfunction

    // Evaluate one active clock edge on the model, from the inputs being applied.
    task automatic model_edge();
        bit   rdy_pre;
        bit   mis;
        ent_t h;
        ent_t n;
        rdy_pre = (mq.size() < DEPTH) && !m_redir;
        mis     = 0;
        m_cmt_v = 0;
        m_mis   = 0;
        if (io.flush_i) begin
            mq.delete();
            m_redir = 0;
            m_wait  = 0;
            return;
        end
        if (m_redir) begin
            if (io.rdr_ack_i) m_redir = 0;
        end else if (mq.size() != 0) begin
            h = mq[0];
            if (h.kind == K_WAIT && io.waitctr_i != 64'd1) begin
                m_wait = 1;
            end else begin
                void'(mq.pop_front());
                m_cmt_v = 1;
                m_id    = h.id;
                m_bus   = m_wait ? 64'd1 : h.bus;
                m_wait  = 0;
                mis     = is_mis(h);
                if (mis) begin
                    m_mis   = 1;
                    m_redir = 1;
                    m_pc    = (h.kind == K_BRANCH && !h.taken) ? h.nextpc : h.tgt;
                    mq.delete();
                end
            end
        end
        if (io.fcu_v_i && rdy_pre && !mis) begin
            n.id = io.fcu_id_i; n.kind = int'(io.fcu_kind_i); n.bus = io.fcu_bus_i;
            n.taken = io.fcu_taken_i; n.tgt = io.fcu_tgt_i; n.nextpc = io.fcu_nextpc_i;
            n.ptaken = io.fcu_ptaken_i; n.ptgt = io.fcu_ptgt_i;
            mq.push_back(n);
        end
    endtask

    task automatic check_all();
        chk("rdy",     io.fcu_rdy_o,     ((mq.size() < DEPTH) && !m_redir) ? 1 : 0);
        chk("cmt_v",   io.cmt_v_o,       m_cmt_v);
        chk("cmt_mis", io.cmt_mispred_o, m_mis);
        chk("cmt_id",  io.cmt_id_o,      m_id);
        chk("cmt_bus", io.cmt_bus_o,     m_bus);
        chk("rdr_v",   io.rdr_v_o,       m_redir);
        chk("rdr_pc",  io.rdr_pc_o,      m_pc);
        chk("wait",    io.wait_active_o, m_wait);
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input logic [3:0] id, input int kind, input logic [63:0] bus,
                         input bit taken, input logic [31:0] tgt, input logic [31:0] nextpc,
                         input bit ptaken, input logic [31:0] ptgt);
        io.fcu_v_i = v; io.fcu_id_i = id; io.fcu_kind_i = 2'(kind); io.fcu_bus_i = bus;
        io.fcu_taken_i = taken; io.fcu_tgt_i = tgt; io.fcu_nextpc_i = nextpc;
        io.fcu_ptaken_i = ptaken; io.fcu_ptgt_i = ptgt;
    endtask

    task automatic push_good(input logic [3:0] id);
        drive(1, id, K_BRANCH, 64'h100 + 64'(id), 1, 32'h1000, 32'h0, 1, 32'h1000);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        io.waitctr_i = 64'd7; io.flush_i = 0; io.rdr_ack_i = 0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Correctly predicted taken branch
        drive(1, 3, K_BRANCH, 64'hABCD, 1, 32'h1000, 32'h0FFC, 1, 32'h1000);
        step();
        chk("lat_early", io.cmt_v_o, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("br_cmt_v", io.cmt_v_o, 1);
        chk("br_id", io.cmt_id_o, 3);
        chk("br_mis", io.cmt_mispred_o, 0);
        chk("br_rdr", io.rdr_v_o, 0);
        step();

        // WAIT at head fills the queue; fifth push is ignored
        io.waitctr_i = 64'd7;
        drive(1, 1, K_WAIT, 64'h55, 0, 0, 0, 0, 0);
        step();
        for (int i = 2; i <= 5; i++) begin
            push_good(4'(i));
            step();
        end
        chk("full_rdy", io.fcu_rdy_o, 0);
        chk("full_wait", io.wait_active_o, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        io.waitctr_i = 64'd1;
        step();
        chk("wait_bus", io.cmt_bus_o, 1);
        chk("wait_id", io.cmt_id_o, 1);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("drain_id", io.cmt_id_o, 64'(i));
        end
        step();
        chk("drain_end", io.cmt_v_o, 0);

        // Branch mispredict with younger entries queued behind it
        io.waitctr_i = 64'd7;
        drive(1, 8, K_WAIT, 64'h0, 0, 0, 0, 0, 0);
        step();
        drive(1, 9, K_BRANCH, 64'h99, 0, 32'h5000, 32'h2004, 1, 32'h5000);
        step();
        push_good(10);
        step();
        push_good(11);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        io.waitctr_i = 64'd1;
        step();
        step();
        chk("mp_id", io.cmt_id_o, 9);
        chk("mp_mis", io.cmt_mispred_o, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mp_hold_v", io.rdr_v_o, 1);
            chk("mp_hold_pc", io.rdr_pc_o, 32'h2004);
        end
        io.rdr_ack_i = 1;
        step();
        io.rdr_ack_i = 0;
        chk("mp_ack_v", io.rdr_v_o, 0);
        chk("mp_ack_rdy", io.fcu_rdy_o, 1);
        repeat (2) begin
            step();
            chk("mp_discard", io.cmt_v_o, 0);
        end

        // RETURN target mispredict, then flush with a coincident push in REDIR
        drive(1, 2, K_RETURN, 64'h77, 0, 32'h3000, 32'h0100, 0, 32'h3008);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("ret_pc", io.rdr_pc_o, 32'h3000);
        chk("ret_v", io.rdr_v_o, 1);
        io.flush_i = 1;
        push_good(6);
        step();
        io.flush_i = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl_rdr", io.rdr_v_o, 0);
        chk("fl_cmt", io.cmt_v_o, 0);
        step();
        chk("fl_drop", io.cmt_v_o, 0);

        // Asynchronous reset while a WAIT is stalled
        io.waitctr_i = 64'd7;
        drive(1, 12, K_WAIT, 64'h0, 0, 0, 0, 0, 0);
        step();
        push_good(13);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rw_wait", io.wait_active_o, 1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        io.waitctr_i = 64'd1;
        repeat (3) begin
            step();
            chk("rw_nowb", io.cmt_v_o, 0);
        end

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [31:0] t;
            t = 32'h4000 + 32'($urandom_range(0, 3) * 4);
            drive(($urandom_range(0, 9) < 6), 4'($urandom), int'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 1'($urandom), t, 32'h8000 + 32'($urandom_range(0, 15)),
                  1'($urandom), ($urandom_range(0, 4) != 0) ? t : t + 32'h10);
            if ($urandom_range(0, 4) != 0) io.fcu_ptaken_i = io.fcu_taken_i;
            io.waitctr_i = ($urandom_range(0, 2) == 0) ? 64'd1 : 64'($urandom_range(2, 9));
            io.rdr_ack_i = ($urandom_range(0, 9) < 3);
            io.flush_i   = ($urandom_range(0, 31) == 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        io.flush_i = 0; io.rdr_ack_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/ft64_fcu_resolve.md
# ft64_fcu_resolve

Resolution stage directly downstream of the FT64 flow-control calculation logic.
- Accepts one resolved flow-control result per cycle (result bus value, actual and predicted outcome), queues it and writes it back to the ROB.
- Detects branch/jump mispredicts and raises a held fetch redirect.
- Sequences WAIT instructions against the wait counter.

## Interface
Parameters:
- WID, 64, result bus width
- AMSB, 31, address MSB
- DEPTH, 4, result queue entries (power of two)
- TAGW, 4, ROB tag width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- fcu_v_i  in  1  result valid
- fcu_rdy_o  out  1  stage can accept (queue not full and state != REDIR)
- fcu_id_i  in  TAGW  ROB tag
- fcu_kind_i  in  2  0=BRANCH, 1=JUMP (JAL/CALL), 2=RETURN (RET/REX), 3=WAIT
- fcu_bus_i  in  WID  calculated result value
- fcu_taken_i  in  1  actual taken
- fcu_tgt_i  in  AMSB+1  actual target
- fcu_nextpc_i  in  AMSB+1  fall-through PC
- fcu_ptaken_i  in  1  predicted taken
- fcu_ptgt_i  in  AMSB+1  predicted target
- waitctr_i  in  WID  wait counter
- flush_i  in  1  pipeline flush from commit
- cmt_v_o  out  1  ROB writeback strobe (one-cycle pulse, no backpressure)
- cmt_id_o  out  TAGW  writeback tag
- cmt_bus_o  out  WID  writeback value
- cmt_mispred_o  out  1  writeback is a mispredict
- rdr_v_o  out  1  fetch redirect request
- rdr_pc_o  out  AMSB+1  redirect PC
- rdr_ack_i  in  1  fetch accepted redirect
- wait_active_o  out  1  WAIT instruction stalled at head

## Operation
- Push when fcu_v_i && fcu_rdy_o; push while not ready is ignored.
- Mispredict:
  - BRANCH: taken != ptaken, or (taken && tgt != ptgt).
  - JUMP/RETURN: tgt != ptgt.
  - WAIT: never.
- Redirect PC = taken ? tgt : nextpc. JUMP/RETURN are always treated as taken.
- FSM states IDLE, REDIR, WAIT:
  - IDLE, queue empty: no action.
  - IDLE, head is WAIT with waitctr_i != 1: go WAIT; head not popped.
  - IDLE, any other head: pop; registered cmt_v_o pulse with head id and bus.
  - IDLE pop of a mispredicted head: also cmt_mispred_o=1, rdr_v_o=1, rdr_pc_o loaded; remaining entries discarded; go REDIR.
  - WAIT: wait_active_o=1. Each cycle compare waitctr_i==1. On match: pop, cmt_bus_o=1, go IDLE.
  - REDIR: rdr_v_o and rdr_pc_o held stable until the rdr_ack_i edge, then go IDLE. fcu_rdy_o=0 throughout.
- flush_i has top priority:
  - Empties the queue, returns to IDLE, clears rdr_v_o and wait_active_o.
  - Suppresses cmt_v_o for that cycle.
  - A push coincident with flush_i is dropped.
- rdr_ack_i outside REDIR is ignored.
- Reset mid-operation: immediate asynchronous clear, identical to the reset values.

## Timing
- Reset values:
  - fcu_rdy_o=1.
  - cmt_v_o, cmt_mispred_o, rdr_v_o, wait_active_o = 0.
  - cmt_id_o, cmt_bus_o, rdr_pc_o = 0.
  - Queue empty, state IDLE.
- Latency: result accepted at edge N into an empty queue, then cmt_v_o high in cycle N+1..N+2, i.e. after edge N+1.
- Throughput: one writeback per cycle in IDLE with back-to-back pushes.
- Full boundary: count==DEPTH forces fcu_rdy_o=0. Push and pop in the same cycle when not full keep the count unchanged. Pointers wrap modulo DEPTH.
- Redirect: rdr_v_o rises with the mispredict writeback. It falls the cycle after the ack edge. fcu_rdy_o returns to 1 in that same cycle.
- WAIT exit: cmt_v_o rises the cycle after waitctr_i==1 is sampled.

## Structure
- Package ft64_fcu_pkg holds:
  - kind encodings;
  - FSM state enum;
  - queue entry struct: id, kind, bus, taken, tgt, nextpc, ptaken, ptgt.
- Sub-module ft64_fcu_fifo: synchronous DEPTH-entry FIFO with push, pop, clear, count and full/empty flags, asynchronous active-low reset.
- Mispredict compare and FSM live in the top.

## Test plan
- BRANCH, id 3, taken=1, tgt=ptgt=0x1000, ptaken=1 -> cmt_v_o pulse 2 cycles after push, cmt_id_o=3, cmt_mispred_o=0, rdr_v_o=0.
- BRANCH taken=0, ptaken=1, nextpc=0x2004 -> cmt_mispred_o=1, rdr_v_o=1 and rdr_pc_o=0x2004 held through 5 cycles without ack, cleared the cycle after rdr_ack_i; queued younger entries never written back.
- Five pushes with no pops possible (WAIT at head, waitctr_i=7) -> fcu_rdy_o=0 after 4 entries, 5th ignored; waitctr_i=1 -> WAIT writes back bus=1, remaining three drain on consecutive cycles.
- RETURN with tgt=0x3000, ptgt=0x3008 -> redirect to 0x3000.
- flush_i asserted in REDIR coincident with fcu_v_i -> rdr_v_o=0 next cycle, queue empty, pushed result dropped, no cmt_v_o.
- rst_ni pulsed low mid-WAIT, asynchronous to clk_i -> all outputs 0 and fcu_rdy_o=1 immediately; no writeback after release.
